// File: rtl/decode_queue.sv
// Instruction buffer between fetch and execute: circular queue of {pc, instr}
// with valid/ready handshakes, single-cycle flush, and a decoded view of the head entry.
module decode_queue #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [XLEN-1:0]              in_pc,
    input  logic [31:0]                  in_instr,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [XLEN-1:0]              out_pc,
    output logic [31:0]                  out_instr,
    output logic [4:0]                   out_rd,
    output logic [4:0]                   out_rs1,
    output logic [4:0]                   out_rs2,
    output logic [11:0]                  out_csr_addr,
    output logic [XLEN-1:0]              out_imm,
    output logic [1:0]                   out_sysop,
    output logic                         out_illegal,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    logic [XLEN-1:0]  pc_q    [DEPTH];
    logic [31:0]      instr_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             enq, deq;
    logic [31:0]      head_instr;
    logic [31:0]      imm32;

    assign in_ready  = (count_q != CNT_W'(DEPTH)) && !flush;
    assign out_valid = (count_q != '0) && !flush;
    assign enq       = in_valid && in_ready;
    assign deq       = out_valid && out_ready;
    assign count     = count_q;

    // Pointer and occupancy next state; flush wins over any handshake.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (enq) tail_d = tail_q + PTR_W'(1);
            if (deq) head_d = head_q + PTR_W'(1);
            if (enq && !deq)      count_d = count_q + CNT_W'(1);
            else if (deq && !enq) count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (enq) begin
            pc_q[tail_q]    <= in_pc;
            instr_q[tail_q] <= in_instr;
        end
    end

    assign head_instr   = instr_q[head_q];
    assign out_pc       = pc_q[head_q];
    assign out_instr    = head_instr;
    assign out_rd       = head_instr[11:7];
    assign out_rs1      = head_instr[19:15];
    assign out_rs2      = head_instr[24:20];
    assign out_csr_addr = head_instr[31:20];

    // Every immediate format carries its sign in instr[31]; extend to 32 first.
    always_comb begin
        imm32       = '0;
        out_illegal = 1'b0;
        case (head_instr[6:0])
            7'h03, 7'h13, 7'h1B, 7'h67, 7'h73:
                imm32 = {{20{head_instr[31]}}, head_instr[31:20]};
            7'h23:
                imm32 = {{20{head_instr[31]}}, head_instr[31:25], head_instr[11:7]};
            7'h63:
                imm32 = {{19{head_instr[31]}}, head_instr[31], head_instr[7],
                         head_instr[30:25], head_instr[11:8], 1'b0};
            7'h17, 7'h37:
                imm32 = {head_instr[31:12], 12'b0};
            7'h6F:
                imm32 = {{11{head_instr[31]}}, head_instr[31], head_instr[19:12],
                         head_instr[20], head_instr[30:21], 1'b0};
            7'h33, 7'h3B:
                imm32 = '0;
            default:
                out_illegal = 1'b1;
        endcase
    end

    assign out_imm = XLEN'($signed(imm32));

    always_comb begin
        out_sysop = 2'd0;
        case (head_instr)
            32'h0000_0073: out_sysop = 2'd1;
            32'h0010_0073: out_sysop = 2'd2;
            32'h3020_0073: out_sysop = 2'd3;
            default:       out_sysop = 2'd0;
        endcase
    end

endmodule

// File: doc/decode_queue.md
# decode_queue

Parametrised instruction buffer and decode stage between fetch and execute. Holds up to DEPTH fetched instructions in a circular queue with valid/ready handshakes on both sides. Presents the head entry fully decoded: register indices, sign-extended immediate, CSR address, system-op class and illegal flag. Supports a single-cycle flush for redirects and traps.

## Interface
Parameters:
- XLEN, 64, data/PC width; immediates are sign-extended to XLEN.
- DEPTH, 4, queue entries; power of two, >= 2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- flush  in  1  discard all entries this cycle.
- in_valid  in  1  fetch offers an instruction.
- in_ready  out  1  queue can accept: count < DEPTH and !flush.
- in_pc  in  XLEN  PC of offered instruction.
- in_instr  in  32  raw instruction.
- out_valid  out  1  head entry available: count != 0 and !flush.
- out_ready  in  1  execute consumes head.
- out_pc  out  XLEN  head PC.
- out_instr  out  32  head raw instruction.
- out_rd, out_rs1, out_rs2  out  5 each  instr[11:7], [19:15], [24:20].
- out_csr_addr  out  12  instr[31:20].
- out_imm  out  XLEN  sign-extended immediate.
- out_sysop  out  2  0 none, 1 ECALL, 2 EBREAK, 3 MRET.
- out_illegal  out  1  opcode not supported.
- count  out  $clog2(DEPTH+1)  occupied entries.

## Operation
- Storage: DEPTH entries of {pc, instr}. Head and tail pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. count is a separate register.
- Enqueue when in_valid && in_ready: write to tail, tail+1.
- Dequeue when out_valid && out_ready: head+1.
- count update:
  - +1 on enqueue only.
  - -1 on dequeue only.
  - Unchanged when both happen or neither happens.
- Full (count == DEPTH): in_ready=0, even if out_ready=1 this cycle. There is no pass-through.
- Empty: out_valid=0. There is no bypass, so a new instruction appears at the output the cycle after it is enqueued.
- Flush has priority over everything. head, tail and count go to 0 at the edge. The same-cycle enqueue and dequeue are suppressed because in_ready=0 and out_valid=0.
- Decode is combinational from the head entry. Outputs are don't-care when out_valid=0; the bench checks them only when out_valid=1.
- Supported opcodes (instr[6:0]): 03, 13, 17, 1B, 23, 33, 37, 3B, 63, 67, 6F, 73 (hex). Any other opcode gives out_illegal=1 and out_imm=0.
- Immediate format by opcode:
  - I (03, 13, 1B, 67, 73): instr[31:20].
  - S (23): {instr[31:25], instr[11:7]}.
  - B (63): {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U (17, 37): {instr[31:12], 12'b0}.
  - J (6F): {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - R (33, 3B): 0.
  - All formats are sign-extended from their top bit to XLEN.
- out_sysop matches the full 32-bit word: 0x00000073 gives 1, 0x00100073 gives 2, 0x30200073 gives 3, anything else gives 0.

## Timing
- Reset (reset_n low, asynchronous): head=tail=count=0, so out_valid=0. in_ready=1 once flush is low. Stored pc/instr are not reset.
- Reset asserted mid-operation empties the queue immediately, without waiting for a clock edge.
- Latency: enqueue at edge t gives out_valid=1 in cycle t+1.
- Throughput: 1 instruction/cycle sustained while out_ready=1, starting from a non-empty, non-full queue.
- Handshake: a producer holding in_valid may change data only after the accepting edge. out_* hold stable while out_valid && !out_ready.
- Wrap-around: after DEPTH enqueues and DEPTH dequeues, pointers return to 0 and ordering is preserved.

## Test plan
- Reset, then enqueue 0x00500093 (addi x1,x0,5) at pc 0x80000000 → next cycle out_valid=1, out_rd=1, out_rs1=0, out_imm=5, out_sysop=0, out_illegal=0, count=1.
- Enqueue 0xFE112E23 (sw x1,-4(x2)) and then 0xFE000CE3 (beq x0,x0,-8) → out_imm=0xFFFFFFFFFFFFFFFC, out_rs2=1, out_rs1=2; after dequeue, out_imm=0xFFFFFFFFFFFFFFF8.
- Fill DEPTH=4 with out_ready=0 → count=4 and in_ready=0. Then set out_ready=1 with in_valid=1 → first cycle dequeue only (count=3), next cycle simultaneous enqueue and dequeue keeps count=3. Run 10 entries total through and check order and wrap-around.
- Queue holding 3 entries; flush=1 with in_valid=1 → in_ready=0 and out_valid=0 that cycle; count=0 afterwards; offered instruction not stored.
- Enqueue 0x00000073, 0x00100073, 0x30200073, 0x0000007F → out_sysop 1, 2, 3, 0 in turn; last has out_illegal=1 and out_imm=0.
- Assert reset_n low between edges with count=2 → count=0 and out_valid=0 before the next rising edge.
